// File: rtl/vth_read_detector.sv
// Quantizes retention-distorted Vth samples into 2-bit MLC symbols and scores them against the written symbols.
// Detection latency 1 cycle; no backpressure: written-symbol FIFO drops on overflow and flags underflow.
module vth_read_detector #(
  parameter int               VTH_W      = 16,
  parameter logic [VTH_W-1:0] THR0_DEF   = 16'h1800,
  parameter logic [VTH_W-1:0] THR1_DEF   = 16'h3000,
  parameter logic [VTH_W-1:0] THR2_DEF   = 16'h4800,
  parameter int               FIFO_DEPTH = 16,
  parameter int               FRAME_LEN  = 4096,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sym_valid,
  input  logic [1:0]       sym_in,
  input  logic             vth_valid,
  input  logic [VTH_W-1:0] vth_in,
  input  logic             thr_wr,
  input  logic [1:0]       thr_sel,
  input  logic [VTH_W-1:0] thr_data,
  output logic             det_valid,
  output logic [1:0]       det_sym,
  output logic             sym_err,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sym_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic             fifo_ovf,
  output logic             fifo_unf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, stateNext;

  logic [VTH_W-1:0] thr0, thr1, thr2;

  logic [1:0]  fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   fifoCount;
  logic          fifoEmpty, fifoFull, doPush, doPop;
  logic [1:0]    wrSym;

  logic [1:0]    detNext;
  logic          symMismatch;
  logic [1:0]    grayDiff;
  logic [1:0]    bitDiff;
  logic [CNT_W:0] bitSum;
  logic [SW-1:0] sampleCnt;
  logic          frameFull, countEn;

  function automatic logic [1:0] toGray(input logic [1:0] s);
    case (s)
      2'd0:    toGray = 2'b11;
      2'd1:    toGray = 2'b10;
      2'd2:    toGray = 2'b00;
      default: toGray = 2'b01;
    endcase
  endfunction

  // Read references; a write lands on the edge, so a same-cycle sample still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr0 <= THR0_DEF;
      thr1 <= THR1_DEF;
      thr2 <= THR2_DEF;
    end else if (thr_wr) begin
      case (thr_sel)
        2'd0:    thr0 <= thr_data;
        2'd1:    thr1 <= thr_data;
        2'd2:    thr2 <= thr_data;
        default: ;
      endcase
    end
  end

  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == (AW+1)'(FIFO_DEPTH));
  assign doPop     = vth_valid && !fifoEmpty;
  assign doPush    = sym_valid && (!fifoFull || doPop);
  assign wrSym     = fifoMem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= sym_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   fifoCount <= fifoCount + (AW+1)'(1);
        2'b01:   fifoCount <= fifoCount - (AW+1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Priority compare: unordered thresholds simply resolve to the first match.
  always_comb begin
    detNext = 2'd3;
    if (vth_in < thr0)      detNext = 2'd0;
    else if (vth_in < thr1) detNext = 2'd1;
    else if (vth_in < thr2) detNext = 2'd2;
  end

  assign symMismatch = (detNext != wrSym);
  assign grayDiff    = toGray(detNext) ^ toGray(wrSym);
  assign bitDiff     = {1'b0, grayDiff[0]} + {1'b0, grayDiff[1]};
  assign bitSum      = {1'b0, bit_err_cnt} + (CNT_W+1)'(bitDiff);

  assign frameFull = (sampleCnt == SW'(FRAME_LEN));
  assign countEn   = (state == RUN) && !start && !frameFull && doPop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_valid <= 1'b0;
      det_sym   <= 2'd0;
      sym_err   <= 1'b0;
    end else begin
      det_valid <= vth_valid;
      if (vth_valid) begin
        det_sym <= detNext;
        sym_err <= doPop && symMismatch;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // start from any state (re)opens a frame and suppresses a pending frame_done.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN: begin
        if (start)          stateNext = RUN;
        else if (frameFull) stateNext = DONE;
      end
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy       = (state == RUN);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
      sampleCnt   <= '0;
    end else if (start) begin
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
      sampleCnt   <= '0;
    end else if (countEn) begin
      sampleCnt <= sampleCnt + SW'(1);
      if (symMismatch && (sym_err_cnt != '1)) sym_err_cnt <= sym_err_cnt + CNT_W'(1);
      bit_err_cnt <= bitSum[CNT_W] ? '1 : bitSum[CNT_W-1:0];
    end
  end

  // Sticky flags; start clears them even if an event coincides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else if (start) begin
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else begin
      if (sym_valid && fifoFull && !vth_valid) fifo_ovf <= 1'b1;
      if (vth_valid && fifoEmpty)              fifo_unf <= 1'b1;
    end
  end

endmodule

// File: doc/vth_read_detector.md
Name: vth_read_detector

Overview:
- Read-side stage directly downstream of the retention distortion stage in the NAND flash channel simulator.
- Consumes the 16-bit retention-distorted threshold voltage stream and quantizes it against three read reference voltages into a 2-bit MLC symbol.
- Compares each detected symbol with the originally written symbol, which is buffered in a FIFO to absorb the retention stage latency.
- Accumulates symbol-error and Gray-coded bit-error counts per frame for raw BER measurement.

Parameters:
- VTH_W, 16: width of voltage samples and thresholds.
- THR0_DEF, 16'h1800: reset value of read reference R0 (boundary between levels 0 and 1).
- THR1_DEF, 16'h3000: reset value of R1 (boundary between levels 1 and 2).
- THR2_DEF, 16'h4800: reset value of R2 (boundary between levels 2 and 3).
- FIFO_DEPTH, 16: written-symbol FIFO entries. Must be a power of 2.
- FRAME_LEN, 4096: detected samples per frame.
- CNT_W, 32: error counter width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse. Clears counters and begins a frame.
- sym_valid, input, 1: a written symbol is present on sym_in.
- sym_in, input, 2: written symbol (0 = erased).
- vth_valid, input, 1: a distorted voltage is present on vth_in (driven by the retention stage outputValid).
- vth_in, input, VTH_W: distorted voltage, unsigned.
- thr_wr, input, 1: threshold write strobe.
- thr_sel, input, 2: selects the threshold to write (0..2). Value 3 is ignored.
- thr_data, input, VTH_W: threshold write value.
- det_valid, output, 1: detection result is valid.
- det_sym, output, 2: detected symbol.
- sym_err, output, 1: det_sym differs from the written symbol.
- busy, output, 1: FSM is in RUN.
- frame_done, output, 1: one-cycle end-of-frame pulse.
- sym_err_cnt, output, CNT_W: symbol errors in the current or last frame.
- bit_err_cnt, output, CNT_W: bit errors in the current or last frame.
- fifo_ovf, output, 1: sticky overflow flag.
- fifo_unf, output, 1: sticky underflow flag.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, thresholds set to their *_DEF values.
- Thresholds:
  - A write on thr_wr takes effect for vth_valid samples from the next cycle onward.
  - Unordered thresholds are not an error; the priority compare below defines the result.
- Written-symbol FIFO:
  - Push on sym_valid. Pop on vth_valid.
  - Push while full with no pop: write dropped, fifo_ovf set.
  - Push and pop together while full: both performed.
  - Pop while empty: fifo_unf set, no pointer move. This includes a simultaneous push, which is stored; there is no bypass path.
  - fifo_ovf and fifo_unf clear only on reset or start.
- Detection (registered, latency 1: det_* valid the cycle after vth_valid):
  - det_sym = 0 if vth_in < R0; 1 if < R1; 2 if < R2; otherwise 3. Unsigned compare, first match wins.
  - sym_err = (det_sym != popped symbol). On underflow, sym_err = 0 and no counting occurs.
- Bit errors:
  - Gray map: 0->11, 1->10, 2->00, 3->01.
  - Bit errors per sample = popcount(gray(det) XOR gray(written)), value 0..2.
- FSM:
  - IDLE: detection and FIFO continue to run; counters hold.
  - IDLE -> RUN on start. Entry clears both counters, the sample counter, and the sticky flags.
  - RUN: each counted sample (det_valid without underflow) adds to sym_err_cnt and bit_err_cnt, updating on the same edge as det_*. The sample counter increments.
  - RUN -> DONE when the sample counter reaches FRAME_LEN.
  - DONE: frame_done = 1 for one cycle, then -> IDLE. Counters freeze until the next start.
  - start during RUN restarts the frame (counters cleared) and does not pulse frame_done.
  - start together with the final sample: the restart wins, with no frame_done.
- Counters saturate at all-ones; no wrap.
- Reset mid-frame aborts the frame with no frame_done.

Test Plan:
- Defaults. Write symbols 0,1,2,3. Apply vth 16'h1000, 16'h2000, 16'h3800, 16'h5000. Expect det_sym 0,1,2,3 one cycle later, sym_err = 0, both counters 0.
- Errors. Written 0 with vth 16'h5000 (det 3): sym_err = 1, bit_err +1 (11^01). Written 1 with vth 16'h4000 (det 2): bit_err +1 (10^00). Written 0 with vth 16'h3800 (det 2): bit_err +2 (11^00).
- Frame. With FRAME_LEN = 8, start, then 8 samples containing 3 errors. Expect frame_done pulse exactly one cycle after the 8th det_valid, sym_err_cnt = 3, counters frozen afterwards.
- Boundaries. vth exactly 16'h1800 -> det 1. Write R1 = 16'h2000, then vth 16'h2000 on the next cycle -> det 2.
- FIFO. Push 17 symbols without pop: fifo_ovf = 1, 16 retained. vth_valid on an empty FIFO: fifo_unf = 1, det_valid = 1, counters unchanged.
- Reset asserted mid-RUN: all outputs 0 immediately, no frame_done, thresholds back to defaults.
